// File: rtl/ram_bist_pkg.sv
// Shared types and the data-pattern helper for the RAM built-in self-test.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StDone
    } state_e;

    // Callers truncate the result to their data width.
    function automatic logic [31:0] pat(input logic [31:0] addr, input logic [31:0] seed,
                                        input logic inv);
        logic [31:0] p;
        p = addr ^ seed;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// Single-port synchronous RAM port as driven by the BIST initiator.
interface ram_bist_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
);
    logic              en;
    logic [DATA_W-1:0] datain;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] dataout;

    modport master (output en, datain, address, input dataout);
    modport slave  (input en, datain, address, output dataout);
endinterface

// File: rtl/ram_bist_cmp.sv
// Read-back checker: delays the expected address/data one cycle to line up with the
// registered RAM output, counts miscompares and captures the first failure.
module ram_bist_cmp #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] exp_addr_i,
    input  logic [DATA_W-1:0] exp_data_i,
    input  logic [DATA_W-1:0] dataout_i,
    output logic              mismatch_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_data_o
);
    logic              valid_q;
    logic [ADDR_W-1:0] exp_addr_q;
    logic [DATA_W-1:0] exp_data_q;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    assign mismatch_o = valid_q && (dataout_i != exp_data_q);

    always_comb begin
        err_count_d = err_count_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (clear_i) begin
            err_count_d = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end else if (mismatch_o) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (err_count_q == '0) begin
                fail_addr_d = exp_addr_q;
                fail_data_d = dataout_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            exp_addr_q  <= '0;
            exp_data_q  <= '0;
            err_count_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            valid_q     <= valid_i;
            exp_addr_q  <= exp_addr_i;
            exp_data_q  <= exp_data_i;
            err_count_q <= err_count_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign err_count_o = err_count_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;

endmodule

// File: rtl/ram_bist.sv
// BIST initiator: writes pattern / reads back over all addresses, then repeats with
// the inverted pattern, and reports pass/fail with first-failure capture.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int unsigned       ADDR_W = 10,
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       DEPTH  = 1024,
    parameter logic [DATA_W-1:0] SEED   = 8'h50,
    parameter int unsigned       CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    ram_bist_if.master        ram,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_data_o
);
    localparam int unsigned     LastInt  = DEPTH - 1;
    localparam logic [ADDR_W:0] LastAddr = LastInt[ADDR_W:0];

    state_e            state_q, state_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              inv_q, inv_d;
    logic              en_q, en_d;
    logic [DATA_W-1:0] datain_q, datain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              clear;
    logic              mismatch;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inv_d   = inv_q;
        pass_d  = pass_q;
        clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StWrite;
                    addr_d  = '0;
                    inv_d   = 1'b0;
                    pass_d  = 1'b0;
                    clear   = 1'b1;
                end
            end
            StWrite, StRead: begin
                if (addr_q == LastAddr) begin
                    addr_d  = '0;
                    state_d = (state_q == StWrite) ? StRead : StDrain;
                end else begin
                    addr_d = addr_q + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
            StDrain: begin
                if (inv_q) begin
                    state_d = StDone;
                    // Last address compares this cycle, so fold its result in directly.
                    pass_d  = (err_count_o == '0) && !mismatch;
                end else begin
                    state_d = StWrite;
                    inv_d   = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Port registers are loaded from next state so they line up with the FSM.
        en_d     = (state_d == StWrite);
        datain_d = '0;
        if (state_d == StWrite || state_d == StRead) begin
            datain_d = DATA_W'(pat(32'(addr_d), 32'(SEED), inv_d));
        end
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            inv_q    <= 1'b0;
            en_q     <= 1'b0;
            datain_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            inv_q    <= inv_d;
            en_q     <= en_d;
            datain_q <= datain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign ram.en      = en_q;
    assign ram.datain  = datain_q;
    assign ram.address = addr_q[ADDR_W-1:0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;

    ram_bist_cmp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .valid_i    (state_q == StRead),
        .exp_addr_i (addr_q[ADDR_W-1:0]),
        .exp_data_i (datain_q),
        .dataout_i  (ram.dataout),
        .mismatch_o (mismatch),
        .err_count_o(err_count_o),
        .fail_addr_o(fail_addr_o),
        .fail_data_o(fail_data_o)
    );

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural RAM with injectable stuck-at bits and a reference model.
module tb_ram_bist;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned CNT_W  = 11;
    localparam logic [7:0]  SEED   = 8'h50;
    localparam int          LATENCY = 2 * (2 * DEPTH + 1) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done, pass;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;

    int n_vec = 0;
    int n_err = 0;

    ram_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_bus ();

    ram_bist #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .SEED  (SEED),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .ram        (ram_bus),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .err_count_o(err_count),
        .fail_addr_o(fail_addr),
        .fail_data_o(fail_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [DEPTH];
    logic [7:0] s0  [DEPTH];
    logic [7:0] s1  [DEPTH];
    logic [7:0] w800[$];
    logic [7:0] w950[$];

    always @(posedge clk) begin
        if (ram_bus.en) begin
            mem[ram_bus.address] <= ram_bus.datain;
            if (ram_bus.address == 10'd800) w800.push_back(ram_bus.datain);
            if (ram_bus.address == 10'd950) w950.push_back(ram_bus.datain);
        end
        ram_bus.dataout <= (mem[ram_bus.address] & ~s0[ram_bus.address]) | s1[ram_bus.address];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat_ref(input int a, input bit inv);
        logic [7:0] p;
        p = 8'(a) ^ SEED;
        return inv ? ~p : p;
    endfunction

    // Whole-test outcome: every address written then read in two passes.
    task automatic ref_model(output int errs, output int faddr, output int fdata);
        logic [7:0] w, r;
        errs = 0; faddr = 0; fdata = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < int'(DEPTH); a++) begin
                w = pat_ref(a, p == 1);
                r = (w & ~s0[a]) | s1[a];
                if (r != w) begin
                    if (errs == 0) begin
                        faddr = a;
                        fdata = int'(r);
                    end
                    errs++;
                end
            end
        end
        if (errs > 2047) errs = 2047;
    endtask

    task automatic clear_faults();
        for (int a = 0; a < int'(DEPTH); a++) begin
            s0[a] = 8'h00;
            s1[a] = 8'h00;
        end
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, ".en"}, 32'(ram_bus.en), 0);
        check_val({tag, ".datain"}, 32'(ram_bus.datain), 0);
        check_val({tag, ".address"}, 32'(ram_bus.address), 0);
        check_val({tag, ".busy"}, 32'(busy), 0);
        check_val({tag, ".done"}, 32'(done), 0);
        check_val({tag, ".pass"}, 32'(pass), 0);
        check_val({tag, ".err_count"}, 32'(err_count), 0);
        check_val({tag, ".fail_addr"}, 32'(fail_addr), 0);
        check_val({tag, ".fail_data"}, 32'(fail_data), 0);
    endtask

    task automatic run_bist(input string tag, input bit extra_start);
        int errs, faddr, fdata, cycles, ndone, done_at;
        ref_model(errs, faddr, fdata);
        w800.delete();
        w950.delete();
        @(negedge clk);
        start   = 1'b1;
        cycles  = 0;
        ndone   = 0;
        done_at = 0;
        while (cycles < LATENCY + 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = extra_start && (cycles == 10);
            if (cycles == 1) begin
                check_val({tag, ".busy_at_1"}, 32'(busy), 1);
                check_val({tag, ".pass_cleared"}, 32'(pass), 0);
                check_val({tag, ".err_cleared"}, 32'(err_count), 0);
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_at == 0) done_at = cycles;
            end
        end
        check_val({tag, ".latency"}, 32'(done_at), 32'(LATENCY));
        check_val({tag, ".done_count"}, 32'(ndone), 1);
        check_val({tag, ".busy_after"}, 32'(busy), 0);
        check_val({tag, ".pass"}, 32'(pass), 32'(errs == 0));
        check_val({tag, ".err_count"}, 32'(err_count), 32'(errs));
        check_val({tag, ".fail_addr"}, 32'(fail_addr), 32'(faddr));
        check_val({tag, ".fail_data"}, 32'(fail_data), 32'(fdata));
        check_val({tag, ".w800_n"}, 32'(w800.size()), 2);
        check_val({tag, ".w800_p0"}, 32'(w800[0]), 32'(pat_ref(800, 1'b0)));
        check_val({tag, ".w800_p1"}, 32'(w800[1]), 32'(pat_ref(800, 1'b1)));
        check_val({tag, ".w950_p0"}, 32'(w950[0]), 32'(pat_ref(950, 1'b0)));
        check_val({tag, ".w950_p1"}, 32'(w950[1]), 32'(pat_ref(950, 1'b1)));
    endtask

    initial begin
        int cycles, ndone, nf, a, b;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'h00;
        clear_faults();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");

        // start coinciding with rst must be ignored
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        check_val("start_in_rst.busy", 32'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        check_val("start_in_rst.busy2", 32'(busy), 0);

        run_bist("ideal", 1'b0);
        check_val("ideal.w800_lit", 32'(w800[0]), 32'h70);
        check_val("ideal.w950_lit", 32'(w950[1]), 32'h19);

        s0[800] = 8'h08;
        run_bist("stuck800", 1'b0);
        check_val("stuck800.fail_data_lit", 32'(fail_data), 32'h87);

        s0[950] = 8'h02;
        run_bist("stuck2", 1'b0);
        check_val("stuck2.fail_addr_lit", 32'(fail_addr), 950);
        check_val("stuck2.err_lit", 32'(err_count), 2);

        run_bist("start_busy", 1'b1);
        run_bist("repeat", 1'b0);

        // abort mid-test with reset
        clear_faults();
        @(negedge clk);
        start  = 1'b1;
        cycles = 0;
        while (cycles < 1500) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("abort");
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check_val("abort.no_done", 32'(ndone), 0);
        check_val("abort.idle_busy", 32'(busy), 0);

        for (int t = 0; t < 3; t++) begin
            clear_faults();
            nf = $urandom_range(0, 4);
            for (int k = 0; k < nf; k++) begin
                a = $urandom_range(0, DEPTH - 1);
                b = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) s0[a] = s0[a] | (8'h01 << b);
                else                           s1[a] = s1[a] | (8'h01 << b);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_bist($sformatf("rand%0d", t), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
